// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, signs fixed up at the end.
module muldiv_unit #(
  parameter int width = 32
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [width-1:0] OperandA,
  input  logic [width-1:0] OperandB,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [width-1:0] MoveData,
  output logic             Busy,
  output logic             Done,
  output logic [width-1:0] Hi,
  output logic [width-1:0] Lo
);
  // state | meaning
  // IDLE  | waiting for Start; MTHI/MTLO accepted
  // RUN   | one multiply/divide iteration per cycle
  // FIX   | apply result signs, write Hi/Lo, pulse Done

  localparam int cntW = $clog2(width + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} stateType;

  stateType               state, nextState;
  logic                   loadOp, finish;
  logic [cntW-1:0]        cnt;
  logic [2*width-1:0]     acc;
  logic [width-1:0]       opB;
  logic [width-1:0]       savedA;
  logic                   isDiv, negLo, negHi, divZero;

  logic                   signedOp, negA, negB;
  logic [width-1:0]       magA, magB;
  logic [width-1:0]       addend;
  logic [width:0]         mulSum, remShift, remDiff;
  logic [2*width-1:0]     mulNext, divNext, prodFix;
  logic [width-1:0]       quoFix, remFix, resHi, resLo;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    loadOp    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (Start) begin
        nextState = RUN;
        loadOp    = 1'b1;
      end
      RUN:  if (cnt == cntW'(1)) nextState = FIX;
      FIX: begin
        nextState = IDLE;
        finish    = 1'b1;
      end
      default: nextState = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

  assign signedOp = ~Op[0];
  assign negA     = signedOp & OperandA[width-1];
  assign negB     = signedOp & OperandB[width-1];
  assign magA     = negA ? -OperandA : OperandA;
  assign magB     = negB ? -OperandB : OperandB;

  assign addend  = acc[0] ? opB : {width{1'b0}};
  assign mulSum  = {1'b0, acc[2*width-1:width]} + {1'b0, addend};
  assign mulNext = {mulSum, acc[width-1:1]};

  // Remainder stays below the divisor, so the borrow bit alone decides the trial subtract.
  assign remShift = acc[2*width-1:width-1];
  assign remDiff  = remShift - {1'b0, opB};
  assign divNext  = remDiff[width] ? {remShift[width-1:0], acc[width-2:0], 1'b0}
                                   : {remDiff[width-1:0], acc[width-2:0], 1'b1};

  always_comb begin
    prodFix = negLo ? -acc : acc;
    quoFix  = negLo ? -acc[width-1:0] : acc[width-1:0];
    remFix  = negHi ? -acc[2*width-1:width] : acc[2*width-1:width];
    resHi   = prodFix[2*width-1:width];
    resLo   = prodFix[width-1:0];
    if (isDiv) begin
      if (divZero) begin
        resHi = savedA;
        resLo = {width{1'b1}};
      end else begin
        resHi = remFix;
        resLo = quoFix;
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      cnt     <= '0;
      acc     <= '0;
      opB     <= '0;
      savedA  <= '0;
      isDiv   <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      divZero <= 1'b0;
      Done    <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      Done <= finish;
      if (state == IDLE) begin
        if (HiWrite) Hi <= MoveData;
        if (LoWrite) Lo <= MoveData;
      end
      if (loadOp) begin
        cnt     <= cntW'(width);
        acc     <= {{width{1'b0}}, Op[1] ? magA : magB};
        opB     <= Op[1] ? magB : magA;
        savedA  <= OperandA;
        isDiv   <= Op[1];
        negLo   <= negA ^ negB;
        negHi   <= Op[1] & negA;
        divZero <= Op[1] & (OperandB == '0);
      end else if (state == RUN) begin
        acc <= isDiv ? divNext : mulNext;
        cnt <= cnt - cntW'(1);
      end
      if (finish) begin
        Hi <= resHi;
        Lo <= resLo;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table plus scoreboard, then
// hand-written sequences for busy interaction, back-to-back issue and reset.
module tb_muldiv_unit;
  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] OperandA = '0, OperandB = '0, MoveData = '0;
  logic        HiWrite = 1'b0, LoWrite = 1'b0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  muldiv_unit #(.width(32)) dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .MoveData(MoveData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vecType;

  typedef struct {
    logic [31:0] hi, lo;
    int          cyc;
  } expType;

  expType sb[$];
  int     checkCnt = 0;
  int     passCnt = 0;
  int     cycleCnt = 0;
  int     doneCnt = 0;

  always @(posedge Clk) cycleCnt <= cycleCnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge Clk) begin
    #1;
    if (ResetN && Done) begin
      expType e;
      doneCnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(Done), 64'(0));
      end else begin
        e = sb.pop_front();
        check("hi", 64'(Hi), 64'(e.hi));
        check("lo", 64'(Lo), 64'(e.lo));
        check("latency", 64'(cycleCnt), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    expType e;
    Op = op; OperandA = a; OperandB = b; Start = 1'b1;
    e.hi = expHi; e.lo = expLo; e.cyc = cycleCnt + 34;
    sb.push_back(e);
    tick();
    Start = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (Busy && n < 100) begin
      tick();
      n++;
    end
    if (Busy) check("idle_timeout", 64'(Busy), 64'(0));
    tick();
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sbv;
    logic [63:0] p;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    hi = '0; lo = '0;
    case (op)
      2'b00: begin p = 64'(sa * sbv); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          lo = 32'(sa / sbv); hi = 32'(sa % sbv);
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  vecType vecs[14];

  initial begin
    logic [31:0] rHi, rLo, ra, rb;
    logic [1:0]  rop;
    int          n, seenDone;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4]  = '{2'b11, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[6]  = '{2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9]  = '{2'b10, 32'hFFFF_FFF8, 32'h0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[11] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF};
    vecs[12] = '{2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14};
    vecs[13] = '{2'b11, 32'd5,         32'd9,         32'd5,         32'd0};

    // reset state
    tick(); tick();
    check("rst_busy", 64'(Busy), 64'(0));
    check("rst_done", 64'(Done), 64'(0));
    check("rst_hi", 64'(Hi), 64'(0));
    check("rst_lo", 64'(Lo), 64'(0));
    #2 ResetN = 1'b1;
    tick();

    // MTHI / MTLO in idle
    HiWrite = 1'b1; MoveData = 32'h0000_DEAD;
    tick();
    HiWrite = 1'b0;
    check("mthi_idle", 64'(Hi), 64'h0000_DEAD);
    LoWrite = 1'b1; MoveData = 32'h0000_BEEF;
    tick();
    LoWrite = 1'b0;
    check("mtlo_idle", 64'(Lo), 64'h0000_BEEF);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      check("busy_after_start", 64'(Busy), 64'(1));
      waitIdle();
    end

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      model(rop, ra, rb, rHi, rLo);
      issue(rop, ra, rb, rHi, rLo);
      waitIdle();
    end

    // MTHI/MTLO in the Start cycle, then Start and MTHI ignored while busy
    HiWrite = 1'b1; LoWrite = 1'b1; MoveData = 32'h0000_1111;
    issue(2'b01, 32'd5, 32'd6, 32'd0, 32'd30);
    HiWrite = 1'b0; LoWrite = 1'b0;
    check("mthi_with_start", 64'(Hi), 64'h0000_1111);
    check("mtlo_with_start", 64'(Lo), 64'h0000_1111);
    repeat (5) tick();
    Start = 1'b1; Op = 2'b11; OperandA = 32'd1000; OperandB = 32'd3;
    HiWrite = 1'b1; MoveData = 32'h0000_DEAD;
    tick();
    Start = 1'b0; HiWrite = 1'b0;
    check("mthi_busy_ignored", 64'(Hi), 64'h0000_1111);
    check("busy_still", 64'(Busy), 64'(1));
    waitIdle();
    check("no_extra_op", 64'(Busy), 64'(0));

    // back-to-back: second Start in the Done cycle
    issue(2'b01, 32'd7, 32'd8, 32'd0, 32'd56);
    n = 0;
    while (!Done && n < 100) begin
      tick();
      n++;
    end
    check("b2b_first_done", 64'(Done), 64'(1));
    issue(2'b01, 32'd5, 32'd6, 32'd0, 32'd30);
    check("b2b_busy", 64'(Busy), 64'(1));
    waitIdle();

    // reset mid-run of a MULTU
    issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd12);
    repeat (10) tick();
    #2 ResetN = 1'b0;
    #1;
    check("midrst_busy", 64'(Busy), 64'(0));
    check("midrst_done", 64'(Done), 64'(0));
    check("midrst_hi", 64'(Hi), 64'(0));
    check("midrst_lo", 64'(Lo), 64'(0));
    sb.delete();
    tick();
    ResetN = 1'b1;
    seenDone = doneCnt;
    repeat (40) tick();
    check("no_done_after_rst", 64'(doneCnt), 64'(seenDone));
    check("idle_after_rst", 64'(Busy), 64'(0));

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS-subset datapath. It sits directly downstream of the register file and consumes the two read ports as operands for MULT/MULTU/DIV/DIVU. It then holds the 2*width-bit result in HI/LO, where MFHI/MFLO pick it up and route it back to the register-file write port. MTHI/MTLO write HI/LO directly.

## Interface
- width, default 32: operand and HI/LO width.
- Clk  input  1  rising-edge clock, single clock domain.
- ResetN  input  1  reset, asynchronous, active-low.
- Start  input  1  launch operation; accepted only when Busy=0.
- Op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with Start.
- OperandA  input  width  rs value (multiplicand/dividend); sampled with Start.
- OperandB  input  width  rt value (multiplier/divisor); sampled with Start.
- HiWrite  input  1  MTHI: load MoveData into Hi.
- LoWrite  input  1  MTLO: load MoveData into Lo.
- MoveData  input  width  data for MTHI/MTLO.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse: Hi/Lo just updated by an operation.
- Hi  output  width  HI register (product high half / remainder).
- Lo  output  width  LO register (product low half / quotient).

## Operation
- FSM states:
  - IDLE: Start=1 latches Op and operands. Signed ops convert operands to magnitudes and record the result sign(s). Go to RUN and load the counter with width.
  - RUN: one iteration per cycle. Multiply is shift-add on the 2*width accumulator. Divide is restoring: shift remainder left, trial-subtract the divisor, set the quotient bit. Decrement the counter; go to FIX when it reaches 1.
  - FIX: apply signs, write Hi/Lo, return to IDLE.
- Sign rules:
  - MULT: product negated when the operand signs differ.
  - DIV: quotient negated when the operand signs differ; remainder takes the dividend's sign.
  - Unsigned ops skip negation.
- Divide by zero: Lo = all ones, Hi = OperandA (as sampled). Same latency; no error flag.
- Signed DIV of most-negative value by -1: Lo = 0x80000000, Hi = 0 (natural truncation); no trap.
- Start while Busy=1 is ignored. Issue logic must stall on Busy.
- HiWrite/LoWrite:
  - While Busy=1: ignored.
  - In IDLE, same cycle as Start: both take effect; the operation result later overwrites Hi/Lo.
- Hi/Lo hold their value at all other times.
- Internal accumulator, remainder and counter are not observable.

## Timing
- Reset (ResetN=0, asynchronous, any state, including mid-operation):
  - State = IDLE; Busy = 0, Done = 0, Hi = 0, Lo = 0; counter and accumulator cleared.
  - An in-flight operation is discarded with no Done.
- Start sampled at edge E0:
  - Busy = 1 from after E0 through cycle width+1 (width RUN cycles + 1 FIX cycle).
  - After edge E(width+1): Hi/Lo show the result, Done = 1 for exactly one cycle, Busy = 0.
  - Total latency from Start edge to result visible: width+1 cycles (33 for width=32).
- A new Start may be accepted in the Done cycle (back-to-back, no bubble).
- MTHI/MTLO in IDLE: new value visible one cycle after the edge.
- Hi/Lo and Done are registered outputs. Busy is decoded from registered state; no combinational input-to-output path.

## Test plan
- Reset: assert ResetN=0 mid-RUN of MULTU -> Busy=0, Done=0, Hi=Lo=0 immediately. After release, no Done pulse appears.
- Signed/unsigned multiply:
  - MULT 0xFFFFFFFE x 0x00000003 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
  - MULTU of the same operands -> Hi=0x00000002, Lo=0xFFFFFFFA.
  - Both: Done exactly 33 cycles after the Start edge.
- Divide signs: DIV -7 / 2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU 100 / 7 -> Lo=14, Hi=2.
- Corner divides:
  - DIVU 0x1234 / 0 -> Lo=0xFFFFFFFF, Hi=0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
  - Both complete in 33 cycles.
- Busy interaction:
  - Start pulsed again mid-operation with different operands -> ignored; result is from the first operation.
  - HiWrite with MoveData=0xDEAD while Busy -> Hi unchanged.
  - HiWrite in IDLE -> Hi=0xDEAD next cycle.
- Back-to-back: second MULTU 5 x 6 started in the Done cycle of the first -> second Done 33 cycles later, Lo=30, Hi=0.
